// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps every N-bit input vector onto a combinational
// gate DUT, waits SETTLE cycles per vector, and compares dut_y against the
// golden function selected by op. Reports error count, first failing vector
// and pass/done status.
module gate_sweep_checker #(
   parameter int N      = 2,
   parameter int SETTLE = 1,
   parameter int ERRW   = N + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [2:0]      op,
   output logic [N-1:0]    dut_a,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_count,
   output logic            first_fail_valid,
   output logic [N-1:0]    first_fail_vec
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

   state_t          state_q;
   logic [N-1:0]    vec_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      op_q;
   logic [N-1:0]    dut_a_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [ERRW-1:0] err_q;
   logic            ffv_q;
   logic [N-1:0]    ffvec_q;

   logic            exp_y;
   logic            mismatch;
   logic [ERRW-1:0] err_d;

   // Golden gate output for the vector currently on dut_a, plus the
   // saturating error count this CHECK would produce.
   always_comb begin
      exp_y = 1'b0;
      case (op_q)
         3'd0: exp_y = &dut_a_q;
         3'd1: exp_y = |dut_a_q;
         3'd2: exp_y = ~&dut_a_q;
         3'd3: exp_y = ~|dut_a_q;
         3'd4: exp_y = ^dut_a_q;
         3'd5: exp_y = ~^dut_a_q;
         3'd6: exp_y = ~dut_a_q[0];
         3'd7: exp_y = dut_a_q[0];
         default: exp_y = 1'b0;
      endcase
      mismatch = (exp_y != dut_y);
      err_d    = err_q;
      if (mismatch && (err_q != '1)) begin
         err_d = err_q + ERRW'(1);
      end
   end

   // Sweep controller: walks DRIVE -> SETTLE -> CHECK per vector with all
   // status outputs registered; abort in any busy state returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         dut_a_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ffv_q   <= 1'b0;
         ffvec_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_q    <= op;
                  err_q   <= '0;
                  ffv_q   <= 1'b0;
                  ffvec_q <= '0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  vec_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else begin
                  dut_a_q <= vec_q;
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else if (cnt_q == '0) begin
                  state_q <= S_CHECK;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_CHECK: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else begin
                  err_q <= err_d;
                  if (mismatch && !ffv_q) begin
                     ffv_q   <= 1'b1;
                     ffvec_q <= dut_a_q;
                  end
                  // pass uses err_d so the final vector's own mismatch counts
                  if (vec_q == '1) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == '0);
                  end else begin
                     vec_q   <= vec_q + N'(1);
                     state_q <= S_DRIVE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dut_a            = dut_a_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: instance 0 has N=2, instance 1
// has N=1. A driver issues sweeps against a behavioural DUT (correct gate,
// wrong gate, or stuck output) and pushes expected results; a monitor pops
// and compares whenever done rises.
module tb_gate_sweep_checker;

   localparam int S = 1;

   typedef struct {
      int a;
      bit busy;
      bit done;
      bit pass;
      int err;
      bit ffv;
      int ffvec;
   } snap_t;

   typedef struct {
      int err;
      bit ffv;
      int ffvec;
      bit pass;
      int done_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s[2];
   logic       abort_s[2];
   logic       y_s[2];
   logic [2:0] op_s[2];

   logic [1:0] a_dut_a;
   logic       a_busy, a_done, a_pass, a_ffv;
   logic [2:0] a_err;
   logic [1:0] a_ffvec;

   logic [0:0] b_dut_a;
   logic       b_busy, b_done, b_pass, b_ffv;
   logic [1:0] b_err;
   logic [0:0] b_ffvec;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   pd[2];
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gate_sweep_checker #(.N(2), .SETTLE(S)) u_a (
      .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .op(op_s[0]),
      .dut_a(a_dut_a), .dut_y(y_s[0]), .busy(a_busy), .done(a_done), .pass(a_pass),
      .err_count(a_err), .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec)
   );

   gate_sweep_checker #(.N(1), .SETTLE(S)) u_b (
      .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .op(op_s[1]),
      .dut_a(b_dut_a), .dut_y(y_s[1]), .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_count(b_err), .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec)
   );

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic snap_t snap(input int i);
      snap_t s;
      if (i == 0) begin
         s.a = int'(a_dut_a); s.busy = a_busy; s.done = a_done; s.pass = a_pass;
         s.err = int'(a_err); s.ffv = a_ffv; s.ffvec = int'(a_ffvec);
      end else begin
         s.a = int'(b_dut_a); s.busy = b_busy; s.done = b_done; s.pass = b_pass;
         s.err = int'(b_err); s.ffv = b_ffv; s.ffvec = int'(b_ffvec);
      end
      return s;
   endfunction

   // Gate truth expressed through counts of set bits rather than reductions.
   function automatic bit gate(input int op, input int v, input int n);
      int ones = 0;
      int all  = (1 << n) - 1;
      for (int b = 0; b < n; b++) ones += (v >> b) & 1;
      case (op)
         0: return v == all;
         1: return v != 0;
         2: return v != all;
         3: return v == 0;
         4: return (ones % 2) == 1;
         5: return (ones % 2) == 0;
         6: return (v % 2) == 0;
         default: return (v % 2) == 1;
      endcase
   endfunction

   // Behavioural DUT: kind 0..7 = that gate, 8 = stuck at 0, 9 = stuck at 1.
   function automatic bit resp(input int kind, input int v, input int n);
      if (kind < 8) return gate(kind, v, n);
      return kind == 9;
   endfunction

   function automatic exp_t model(input int n, input int op, input int kind, input int nvec);
      exp_t e;
      e.err = 0; e.ffv = 0; e.ffvec = 0; e.done_cyc = 0;
      for (int v = 0; v < nvec; v++) begin
         if (resp(kind, v, n) != gate(op, v, n)) begin
            if (!e.ffv) begin
               e.ffv   = 1;
               e.ffvec = v;
            end
            if (e.err < (1 << (n + 1)) - 1) e.err++;
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   // One sweep on instance i. mid: issue an ignored start mid-sweep.
   // abort_m / rst_m: negedge index (edges after the start edge) at which to
   // abort or reset; -1 disables.
   task automatic run(input int i, input int op, input int kind, input bit mid,
                      input int abort_m, input int rst_m);
      int    n, total, c0;
      bit    cut;
      exp_t  e, p;
      snap_t s;
      n     = (i == 0) ? 2 : 1;
      total = (1 << n) * (S + 2);
      cut   = (abort_m >= 0) || (rst_m >= 0);
      @(negedge clk);
      op_s[i]    = 3'(op);
      start_s[i] = 1'b1;
      abort_s[i] = 1'($urandom % 2);
      c0 = cyc;
      e = model(n, op, kind, 1 << n);
      e.done_cyc = c0 + 1 + total;
      if (!cut) begin
         if (i == 0) q0.push_back(e);
         else q1.push_back(e);
      end
      for (int m = 0; m <= total; m++) begin
         @(negedge clk);
         s = snap(i);
         if (m == 0) begin
            start_s[i] = 1'b0;
            abort_s[i] = 1'b0;
            chk("start_clears_err", s.err, 0);
            chk("start_clears_ffv", s.ffv, 0);
            chk("busy_after_start", s.busy, 1);
            chk("done_after_start", s.done, 0);
         end
         if (m >= 1) chk("dut_a_seq", s.a, (m - 1) / (S + 2));
         if (!cut && m == total - 1) chk("done_early", s.done, 0);
         if (mid && m == 2) begin
            start_s[i] = 1'b1;
            op_s[i]    = 3'(op ^ (1 + int'($urandom % 7)));
         end
         if (mid && m == 3) start_s[i] = 1'b0;
         if (abort_m >= 0 && m == abort_m) abort_s[i] = 1'b1;
         if (abort_m >= 0 && m == abort_m + 1) begin
            abort_s[i] = 1'b0;
            p = model(n, op, kind, abort_m / (S + 2));
            chk("abort_busy", s.busy, 0);
            chk("abort_done", s.done, 0);
            chk("abort_err_kept", s.err, p.err);
            chk("abort_ffv_kept", s.ffv, p.ffv);
            break;
         end
         if (m == rst_m) begin
            p = model(n, op, kind, m / (S + 2));
            chk("pre_rst_err", s.err, p.err);
            #1 rst = 1'b1;
            #1 s = snap(i);
            chk("rst_async_dut_a", s.a, 0);
            chk("rst_async_err", s.err, 0);
            chk("rst_async_ffv", s.ffv, 0);
            chk("rst_async_busy", s.busy, 0);
            @(negedge clk);
            rst = 1'b0;
            break;
         end
         y_s[i] = ((m + 1) % (S + 2) == 0) ? resp(kind, s.a, n) : 1'($urandom % 2);
      end
   endtask

   // abort while DONE must leave the reported results alone.
   task automatic idle_abort(input int i, input exp_t e);
      snap_t s;
      @(negedge clk);
      abort_s[i] = 1'b1;
      @(negedge clk);
      abort_s[i] = 1'b0;
      s = snap(i);
      chk("done_abort_done", s.done, 1);
      chk("done_abort_err", s.err, e.err);
      chk("done_abort_pass", s.pass, e.pass);
   endtask

   // Monitor: compare the completed sweep against the scoreboard head.
   always @(negedge clk) begin : mon
      snap_t s;
      exp_t  e;
      for (int i = 0; i < 2; i++) begin
         s = snap(i);
         if (s.done && !pd[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               chk("done_cycle", cyc, e.done_cyc);
               chk("done_busy", s.busy, 0);
               chk("err_count", s.err, e.err);
               chk("pass", s.pass, e.pass);
               chk("ffv", s.ffv, e.ffv);
               if (e.ffv) chk("first_fail_vec", s.ffvec, e.ffvec);
            end
         end
         pd[i] = s.done;
      end
   end

   initial begin
      snap_t s;
      int    ti, top, tkind;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0; abort_s[i] = 1'b0; y_s[i] = 1'b0; op_s[i] = 3'd0;
      end
      repeat (2) @(negedge clk);
      s = snap(0);
      chk("reset_dut_a", s.a, 0);
      chk("reset_busy", s.busy, 0);
      chk("reset_done", s.done, 0);
      chk("reset_pass", s.pass, 0);
      chk("reset_err", s.err, 0);
      chk("reset_ffv", s.ffv, 0);
      rst = 1'b0;

      run(0, 0, 0, 0, -1, -1);          // AND, correct DUT
      run(0, 0, 8, 0, -1, -1);          // AND, stuck-at-0 DUT
      run(0, 4, 0, 0, -1, -1);          // XOR expected, AND DUT
      idle_abort(0, model(2, 4, 0, 4));
      run(1, 6, 6, 0, -1, -1);          // N=1 inverter
      run(1, 6, 7, 0, -1, -1);          // N=1 buffer against NOT
      run(0, 0, 0, 1, -1, -1);          // ignored mid-sweep start
      run(0, 3, 8, 1, -1, 5);           // reset mid-sweep
      run(0, 0, 0, 0, -1, -1);          // clean sweep after reset
      run(0, 4, 0, 0, 7, -1);           // abort in SETTLE of vector 2
      run(0, 4, 0, 0, -1, -1);          // restart clears partial results

      for (int t = 0; t < 24; t++) begin
         ti    = int'($urandom % 2);
         top   = int'($urandom % 8);
         tkind = ($urandom % 2) != 0 ? top : int'($urandom % 10);
         run(ti, top, tkind, 1'($urandom % 2), -1, -1);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q0.size() + q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Parametrised, clocked, self-checking stimulus/check engine for N-input logic gates. It is the synthesizable successor to the fixed 1-input directed gate benches.
- On start it sweeps every input vector 0..2^N-1 onto the DUT and waits a programmable settle time. It then compares the DUT output against an internal golden model for the selected gate function.
- It reports the error count, the first failing vector and a pass/done status.
- It sits between a bench/top-level controller and one combinational gate DUT.

Parameters:
- N, 2, DUT input width (1..8).
- SETTLE, 1, cycles to wait after driving a vector before sampling dut_y (>=1).
- ERRW, N+1, width of err_count; must hold 2^N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep when not busy.
- abort  input  1  terminates a running sweep.
- op  input  3  gate select, sampled on accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT (~a[0]), 7 BUF (a[0]).
- dut_a  output  N  registered stimulus vector to the DUT.
- dut_y  input  1  DUT output.
- busy  output  1  high from accepted start until DONE/IDLE.
- done  output  1  sweep completed; held until next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERRW  mismatches in the current/last sweep; saturates at all-ones.
- first_fail_valid  output  1  at least one mismatch has been captured.
- first_fail_vec  output  N  vector of the first mismatch.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - dut_a=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0.
  - Internal vec, settle counter and op_q are cleared.
  - Reset asserted mid-sweep discards all results immediately.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE / DONE + start:
  - Latch op_q=op; clear err_count, first_fail_*, done, pass.
  - vec=0; busy=1; go to DRIVE.
- start while busy: ignored, including op.
- DRIVE (1 cycle): dut_a<=vec; settle counter<=SETTLE-1; go to SETTLE.
- SETTLE: hold SETTLE cycles total, decrementing the counter; go to CHECK when the counter reaches 0.
- CHECK (1 cycle): compute expected from dut_a and op_q, using reduction over all N bits for op 0-5 and bit 0 only for op 6/7. Compare with dut_y.
  - On mismatch: err_count+1, saturating.
  - On the first mismatch: first_fail_valid<=1, first_fail_vec<=dut_a.
  - If vec==2^N-1 (the wrap point): go to DONE, busy<=0, done<=1, pass<=(final err_count==0), with the current CHECK's mismatch included.
  - Otherwise vec<=vec+1 and go to DRIVE.
- Latency: SETTLE+2 cycles per vector. done rises 2^N*(SETTLE+2) cycles after the start cycle.
- abort (any busy state): next state IDLE, busy=0, done=0, pass=0. err_count and first_fail_* keep their partial values. dut_a holds its last value.
- abort and start together in IDLE: start wins.
- abort in IDLE or DONE: no effect.
- dut_y is sampled only in CHECK; X or changes in other states are ignored.

Test Plan:
- N=2, SETTLE=1, op=0, correct AND DUT, start pulse:
  - dut_a sequence 0,1,2,3.
  - done=1 and busy=0 exactly 12 cycles after start.
  - err_count=0, pass=1, first_fail_valid=0.
- Same setup, dut_y stuck at 0:
  - err_count=1, pass=0, first_fail_vec=2'b11.
- N=2, op=4 (XOR), DUT is AND:
  - Mismatches at 01, 10 and 11, so err_count=3.
  - first_fail_vec=2'b01, pass=0.
- N=1, op=6, correct inverter:
  - dut_a 0 then 1, pass=1 after 6 cycles.
  - Rerun with a buffer DUT: err_count=2, first_fail_vec=0.
- Busy-state controls: start with op=1 during a sweep, then rst at cycle 5:
  - The mid-sweep start is ignored; op_q stays 0.
  - On rst all outputs go to 0 asynchronously, before the next clk edge.
  - A subsequent start performs a full clean sweep.
- Abort: abort during SETTLE of vector 2:
  - IDLE next cycle, busy=0, done=0.
  - err_count retains its value; a new start clears it.
